// File: rtl/spi_xfer_ctrl_pkg.sv
// Shared definitions for the SPI transfer controller: FSM state encoding,
// data width, edge count per byte and the divider-to-half-period mapping
// used by the sclk generator.
package spi_xfer_ctrl_pkg;

  localparam int DATA_W   = 8;
  localparam int EDGE_CNT = 16;
  localparam int DIV_W    = 3;
  localparam int HALF_W   = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_e;

  // sclk half-period in clk cycles for each divider setting; the unused
  // encodings fall back to the same rate as 3'b001.
  function automatic logic [HALF_W-1:0] half_period(input logic [DIV_W-1:0] div);
    case (div)
      3'b000:  return 5'd2;
      3'b001:  return 5'd5;
      3'b010:  return 5'd9;
      3'b011:  return 5'd17;
      default: return 5'd5;
    endcase
  endfunction

endpackage

// File: rtl/spi_xfer_ctrl_clkgen.sv
// sclk generator for the SPI transfer controller.
// Ports:
//   clk, rst  - system clock, asynchronous active-high reset
//   cs_i      - active-low enable; while high sclk rests at cpol_i
//   div_i     - rate select, mapped through half_period()
//   cpol_i    - idle level of sclk
//   sclk_o    - generated serial clock
module spi_xfer_ctrl_clkgen
  import spi_xfer_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             cs_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             cpol_i,
  output logic             sclk_o
);

  logic [HALF_W-1:0] cnt_q;
  logic [HALF_W-1:0] cnt_d;
  logic [HALF_W-1:0] half;
  logic              phase_q;

  assign half  = half_period(div_i);
  assign cnt_d = cnt_q + 5'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (cs_i) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (cnt_q == half - 5'd1) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_d;
    end
  end

  // Phase is relative to the idle level, so sclk sits at cpol whenever the
  // generator is disabled or held in reset.
  assign sclk_o = cpol_i ^ phase_q;

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI master for single-byte transfers in any of the four SPI modes.
// Ports:
//   clk, rst           - system clock, asynchronous active-high reset
//   start              - one-cycle request, accepted only in IDLE
//   tx_data, divider,
//   cpol, cpha         - transfer configuration, latched on accepted start
//   miso               - serial data from slave
//   sclk, mosi, cs_n   - SPI bus
//   busy               - transfer in progress (XFER and HOLD)
//   done               - one-cycle end-of-transfer pulse
//   rx_data            - received byte, updated together with done
module spi_xfer_ctrl
  import spi_xfer_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [DIV_W-1:0]  divider,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data
);

  state_e            state_q;
  logic [DATA_W-1:0] tx_sh_q;
  logic [DATA_W-1:0] rx_sh_q;
  logic [DATA_W-1:0] rx_data_q;
  logic [4:0]        edge_cnt_q;
  logic [4:0]        edge_cnt_d;
  logic              hold_cnt_q;
  logic [DIV_W-1:0]  div_q;
  logic              cpol_q;
  logic              cpha_q;
  logic              gen_cs_q;
  logic              sclk_prev_q;
  logic              cs_n_q;
  logic              busy_q;
  logic              done_q;

  logic sclk_w;
  logic sclk_edge;
  logic lead_edge;
  logic trail_edge;
  logic last_edge;
  logic do_sample;
  logic do_shift;

  spi_xfer_ctrl_clkgen u_clkgen (
    .clk    (clk),
    .rst    (rst),
    .cs_i   (gen_cs_q),
    .div_i  (div_q),
    .cpol_i (cpol_q),
    .sclk_o (sclk_w)
  );

  // Edges are seen one clk after sclk moves, by comparing with the copy of
  // sclk registered on the previous cycle.
  assign sclk_edge  = (state_q == XFER) && (sclk_w != sclk_prev_q);
  assign lead_edge  = sclk_edge && (sclk_w != cpol_q);
  assign trail_edge = sclk_edge && (sclk_w == cpol_q);
  assign last_edge  = sclk_edge && (edge_cnt_q == 5'(EDGE_CNT - 1));
  assign edge_cnt_d = edge_cnt_q + 5'd1;

  // Mode 0/2: sample on leading, launch on trailing (the last trailing edge
  // ends the byte, so nothing is launched there).
  // Mode 1/3: launch on leading, except the first since bit 7 is already on
  // mosi from the start, and sample on trailing.
  assign do_sample = cpha_q ? trail_edge : lead_edge;
  assign do_shift  = cpha_q ? (lead_edge && (edge_cnt_q != 5'd0))
                            : (trail_edge && !last_edge);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      rx_data_q   <= '0;
      edge_cnt_q  <= '0;
      hold_cnt_q  <= 1'b0;
      div_q       <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      gen_cs_q    <= 1'b1;
      sclk_prev_q <= 1'b0;
      cs_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_w;
      done_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            div_q       <= divider;
            cpol_q      <= cpol;
            cpha_q      <= cpha;
            tx_sh_q     <= tx_data;
            rx_sh_q     <= '0;
            edge_cnt_q  <= '0;
            cs_n_q      <= 1'b0;
            busy_q      <= 1'b1;
            gen_cs_q    <= 1'b0;
            // sclk jumps to the new cpol here; seed the edge detector with
            // it so a mode change is not mistaken for an sclk edge.
            sclk_prev_q <= cpol;
            state_q     <= XFER;
          end
        end
        XFER: begin
          if (sclk_edge) edge_cnt_q <= edge_cnt_d;
          if (do_sample) rx_sh_q <= {rx_sh_q[DATA_W-2:0], miso};
          if (do_shift)  tx_sh_q <= {tx_sh_q[DATA_W-2:0], 1'b0};
          if (last_edge) begin
            gen_cs_q   <= 1'b1;
            hold_cnt_q <= 1'b0;
            state_q    <= HOLD;
          end
        end
        HOLD: begin
          if (hold_cnt_q) begin
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            rx_data_q <= rx_sh_q;
            state_q   <= DONE;
          end else begin
            hold_cnt_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // mosi is the MSB of the tx shift register, so it keeps the last bit
  // driven once the transfer is over.
  assign sclk    = sclk_w;
  assign mosi    = tx_sh_q[DATA_W-1];
  assign cs_n    = cs_n_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;

endmodule
